// File: rtl/motor_pkg.sv
// Shared types, widths and helpers for the motor duty ramp controller.
package motor_pkg;

    localparam int DUTY_W = 11;
    localparam int SPD_W  = 12;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 11'd2047;

    // HOLD: on target; RAMP: stepping toward target; DECEL: stepping to 0
    // before a reversal; BRAKE: parked at 0 with brake asserted.
    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_DECEL = 2'd2,
        ST_BRAKE = 2'd3
    } state_e;

    // Move cur toward tgt by at most step; never passes tgt, so never wraps.
    function automatic logic [DUTY_W-1:0] step_toward(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input logic [DUTY_W-1:0] step
    );
        logic [DUTY_W-1:0] diff;
        if (tgt >= cur) begin
            diff = tgt - cur;
            return cur + ((diff > step) ? step : diff);
        end else begin
            diff = cur - tgt;
            return cur - ((diff > step) ? step : diff);
        end
    endfunction

endpackage

// File: rtl/sat_abs.sv
// Saturating absolute value of a signed speed command plus its sign bit.
module sat_abs
    import motor_pkg::*;
(
    input  logic signed [SPD_W-1:0]  val,
    output logic        [DUTY_W-1:0] mag,
    output logic                     neg
);

    logic [SPD_W-1:0] negated;

    // -2048 has no positive 12-bit counterpart, so it clamps to DUTY_MAX.
    always_comb begin
        mag     = '0;
        neg     = val[SPD_W-1];
        negated = SPD_W'(-val);
        if (val == -12'sd2048) begin
            mag = DUTY_MAX;
        end else if (val[SPD_W-1]) begin
            mag = negated[DUTY_W-1:0];
        end else begin
            mag = val[DUTY_W-1:0];
        end
    end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Slew-limited motor duty controller with decelerate/brake/reverse sequencing.
// Handshake: a command is taken on a rising clk edge where cmd_vld and
// cmd_rdy are both high; cmd_rdy depends only on state and drops in BRAKE.
module motor_ramp_ctrl
    import motor_pkg::*;
#(
    parameter int STEP          = 16,
    parameter int BRAKE_PERIODS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_vld,
    input  logic signed [SPD_W-1:0]  cmd_spd,
    output logic                     cmd_rdy,
    input  logic                     pwm_wrap,
    output logic        [DUTY_W-1:0] duty,
    output logic                     dir,
    output logic                     brake,
    output logic                     busy,
    output state_e                   state_dbg
);

    localparam int CNT_W = (BRAKE_PERIODS < 1) ? 1 : $clog2(BRAKE_PERIODS + 1);
    localparam logic [CNT_W-1:0]  BRK_LAST = CNT_W'(BRAKE_PERIODS - 1);
    localparam logic [DUTY_W-1:0] STEP_V   = DUTY_W'(STEP);

    state_e             state_q,   state_d;
    logic [DUTY_W-1:0]  duty_q,    duty_d;
    logic               dir_q,     dir_d;
    logic               brake_q,   brake_d;
    logic [DUTY_W-1:0]  tgt_mag_q, tgt_mag_d;
    logic               tgt_dir_q, tgt_dir_d;
    logic [CNT_W-1:0]   brk_cnt_q, brk_cnt_d;

    logic [DUTY_W-1:0]  cmd_mag;
    logic               cmd_neg;
    logic               cmd_dir;
    logic               accept;

    sat_abs u_sat_abs (
        .val (cmd_spd),
        .mag (cmd_mag),
        .neg (cmd_neg)
    );

    assign cmd_rdy   = (state_q != ST_BRAKE);
    assign accept    = cmd_vld & cmd_rdy;
    assign duty      = duty_q;
    assign dir       = dir_q;
    assign brake     = brake_q;
    assign busy      = (state_q != ST_HOLD);
    assign state_dbg = state_q;

    // Next state: the wrap step uses the stored target; a command taken in
    // the same cycle is classified against the post-wrap duty/dir.
    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        dir_d     = dir_q;
        brake_d   = brake_q;
        tgt_mag_d = tgt_mag_q;
        tgt_dir_d = tgt_dir_q;
        brk_cnt_d = brk_cnt_q;
        cmd_dir   = dir_q;

        if (pwm_wrap) begin
            case (state_q)
                ST_HOLD: begin
                end
                ST_RAMP: begin
                    if ((tgt_dir_q != dir_q) && (duty_q != '0)) begin
                        state_d = ST_DECEL;
                    end else begin
                        // At duty 0 a wrong dir flips right away, no braking.
                        dir_d  = tgt_dir_q;
                        duty_d = step_toward(duty_q, tgt_mag_q, STEP_V);
                        if (duty_d == tgt_mag_q) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_DECEL: begin
                    if (tgt_dir_q == dir_q) begin
                        state_d = ST_RAMP;
                    end else begin
                        duty_d = step_toward(duty_q, '0, STEP_V);
                        if (duty_d == '0) begin
                            brake_d   = 1'b1;
                            brk_cnt_d = '0;
                            state_d   = ST_BRAKE;
                        end
                    end
                end
                ST_BRAKE: begin
                    duty_d = '0;
                    if (brk_cnt_q == BRK_LAST) begin
                        brk_cnt_d = '0;
                        brake_d   = 1'b0;
                        dir_d     = tgt_dir_q;
                        state_d   = ST_RAMP;
                    end else begin
                        brk_cnt_d = brk_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_HOLD;
            endcase
        end

        if (accept) begin
            // A zero command carries no direction and keeps the current one.
            cmd_dir   = (cmd_mag == '0) ? dir_d : cmd_neg;
            tgt_mag_d = cmd_mag;
            tgt_dir_d = cmd_dir;
            case (state_d)
                ST_HOLD, ST_RAMP: begin
                    if ((cmd_dir != dir_d) && (duty_d != '0)) begin
                        state_d = ST_DECEL;
                    end else begin
                        state_d = ST_RAMP;
                    end
                end
                ST_DECEL: begin
                    if (cmd_dir == dir_d) begin
                        state_d = ST_RAMP;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers; reset clears any pending target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_HOLD;
            duty_q    <= '0;
            dir_q     <= 1'b0;
            brake_q   <= 1'b0;
            tgt_mag_q <= '0;
            tgt_dir_q <= 1'b0;
            brk_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            dir_q     <= dir_d;
            brake_q   <= brake_d;
            tgt_mag_q <= tgt_mag_d;
            tgt_dir_q <= tgt_dir_d;
            brk_cnt_q <= brk_cnt_d;
        end
    end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl: a cycle vector table plus hand-written
// ramp, saturation, reversal and asynchronous reset sequences.
module tb_motor_ramp_ctrl;
    import motor_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_vld = 1'b0;
    logic signed [11:0] cmd_spd = '0;
    logic              cmd_rdy;
    logic              pwm_wrap = 1'b0;
    logic [10:0]       duty;
    logic              dir;
    logic              brake;
    logic              busy;
    state_e            state_dbg;

    int checks = 0;
    int errors = 0;

    motor_ramp_ctrl #(.STEP(16), .BRAKE_PERIODS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_vld   (cmd_vld),
        .cmd_spd   (cmd_spd),
        .cmd_rdy   (cmd_rdy),
        .pwm_wrap  (pwm_wrap),
        .duty      (duty),
        .dir       (dir),
        .brake     (brake),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        logic               wrap;
        logic               vld;
        logic signed [11:0] spd;
        int                 duty;
        logic               dir;
        logic               brk;
        logic               rdy;
        logic               busy;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input int e_duty, input logic e_dir,
                            input logic e_brk, input logic e_rdy, input logic e_busy);
        chk({name, ".duty"},  32'(duty),    32'(e_duty));
        chk({name, ".dir"},   32'(dir),     32'(e_dir));
        chk({name, ".brake"}, 32'(brake),   32'(e_brk));
        chk({name, ".rdy"},   32'(cmd_rdy), 32'(e_rdy));
        chk({name, ".busy"},  32'(busy),    32'(e_busy));
    endtask

    // One clock: inputs set at negedge, outputs settled 1 ns after posedge.
    task automatic tick(input logic w, input logic v, input logic signed [11:0] s);
        @(negedge clk);
        pwm_wrap = w;
        cmd_vld  = v;
        cmd_spd  = s;
        @(posedge clk);
        #1;
        pwm_wrap = 1'b0;
        cmd_vld  = 1'b0;
        cmd_spd  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Asynchronous reset between clock edges, checked before any edge.
    task automatic async_reset(input string name);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs(name, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // {wrap, vld, spd, duty, dir, brake, rdy, busy}
        vecs[0]  = '{1'b0, 1'b1,  12'sd20,    0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, 1'b0,  12'sd0,    16, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1'b1, 1'b1,  12'sd30,   20, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 1'b0,  12'sd0,    30, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0,  12'sd0,    30, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1,  12'sd0,    30, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b0,  12'sd0,    14, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b0,  12'sd0,     0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, -12'sd5,     0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 1'b0,  12'sd0,     5, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0,  12'sd0,     5, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1,  12'sd3,     5, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b0,  12'sd0,     0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, -12'sd100,   0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b0,  12'sd0,     0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 1'b0,  12'sd0,     0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 1'b0,  12'sd0,     0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 1'b0,  12'sd0,     0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[18] = '{1'b1, 1'b0,  12'sd0,     3, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 1'b1, -12'sd64,    3, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[20] = '{1'b0, 1'b1,  12'sd40,    3, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[21] = '{1'b1, 1'b0,  12'sd0,    19, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[22] = '{1'b1, 1'b0,  12'sd0,    35, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[23] = '{1'b1, 1'b0,  12'sd0,    40, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset values while rst_n is held low
        #3;
        chk_outs("reset", 0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_reset();

        // Vector table: small step, same-cycle command, zero, flip, brake
        for (int i = 0; i < 24; i++) begin
            tick(vecs[i].wrap, vecs[i].vld, vecs[i].spd);
            chk_outs($sformatf("vec%0d", i), vecs[i].duty, vecs[i].dir,
                     vecs[i].brk, vecs[i].rdy, vecs[i].busy);
        end

        // +512 from idle: 16 per wrap, on target after 32 wraps
        do_reset();
        tick(1'b0, 1'b1, 12'sd512);
        for (int k = 1; k <= 32; k++) begin
            tick(1'b1, 1'b0, 12'sd0);
            chk_outs($sformatf("up512_w%0d", k), 16 * k, 1'b0, 1'b0, 1'b1, (k == 32) ? 1'b0 : 1'b1);
        end

        // -2048 from idle: dir flips on first wrap, saturates at 2047
        do_reset();
        tick(1'b0, 1'b1, -12'sd2048);
        for (int k = 1; k <= 128; k++) begin
            tick(1'b1, 1'b0, 12'sd0);
            if (k == 1 || k == 127 || k == 128)
                chk_outs($sformatf("sat_w%0d", k), (k == 128) ? 2047 : 16 * k,
                         1'b1, 1'b0, 1'b1, (k == 128) ? 1'b0 : 1'b1);
        end

        // Hold +256, then -128: decel 16 wraps, brake 4 wraps, ramp 8 wraps
        do_reset();
        tick(1'b0, 1'b1, 12'sd256);
        for (int k = 1; k <= 16; k++) tick(1'b1, 1'b0, 12'sd0);
        chk_outs("rev_hold", 256, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, -12'sd128);
        chk_outs("rev_acc", 256, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 15; k++) begin
            tick(1'b1, 1'b0, 12'sd0);
            chk_outs($sformatf("rev_dec%0d", k), 256 - 16 * k, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        for (int k = 16; k <= 19; k++) begin
            tick(1'b1, 1'b0, 12'sd0);
            chk_outs($sformatf("rev_brk%0d", k), 0, 1'b0, 1'b1, 1'b0, 1'b1);
        end
        tick(1'b1, 1'b0, 12'sd0);
        chk_outs("rev_flip", 0, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 1'b0, 12'sd0);
            chk_outs($sformatf("rev_up%0d", k), 16 * k, 1'b1, 1'b0, 1'b1, (k == 8) ? 1'b0 : 1'b1);
        end

        // Async reset mid-ramp at duty 160, then no stepping afterwards
        do_reset();
        tick(1'b0, 1'b1, 12'sd512);
        for (int k = 1; k <= 10; k++) tick(1'b1, 1'b0, 12'sd0);
        chk_outs("mid_ramp", 160, 1'b0, 1'b0, 1'b1, 1'b1);
        async_reset("rst_ramp");
        for (int k = 1; k <= 3; k++) begin
            tick(1'b1, 1'b0, 12'sd0);
            chk_outs($sformatf("post_ramp%0d", k), 0, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Async reset mid-brake, then no stepping afterwards
        tick(1'b0, 1'b1, 12'sd64);
        for (int k = 1; k <= 4; k++) tick(1'b1, 1'b0, 12'sd0);
        tick(1'b0, 1'b1, -12'sd64);
        for (int k = 1; k <= 5; k++) tick(1'b1, 1'b0, 12'sd0);
        chk_outs("mid_brake", 0, 1'b0, 1'b1, 1'b0, 1'b1);
        async_reset("rst_brake");
        for (int k = 1; k <= 5; k++) begin
            tick(1'b1, 1'b0, 12'sd0);
            chk_outs($sformatf("post_brake%0d", k), 0, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
